// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: opcodes, instruction field layout and fetch states.
package risc_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned FIELD_W = 4;

    // Instruction field positions: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_LSB = 4;
    localparam int unsigned RS2_LSB = 0;

    localparam logic [FIELD_W-1:0] OP_ADD   = 4'b0000;
    localparam logic [FIELD_W-1:0] OP_AND   = 4'b0001;
    localparam logic [FIELD_W-1:0] OP_OR    = 4'b0010;
    localparam logic [FIELD_W-1:0] OP_SUB   = 4'b0011;
    localparam logic [FIELD_W-1:0] OP_LOAD  = 4'b0100;
    localparam logic [FIELD_W-1:0] OP_STORE = 4'b0101;
    localparam logic [FIELD_W-1:0] OP_JUMP  = 4'b0110;
    localparam logic [FIELD_W-1:0] OP_HALT  = 4'b1111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StIssue,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch-and-issue sequencer: owns the PC, fetches over req/valid, resolves jump/halt locally
// and issues decoded fields downstream over a valid/ready handshake.
module instr_fetch_unit
    import risc_pkg::*;
#(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [FIELD_W-1:0] opcode,
    output logic [FIELD_W-1:0] rd,
    output logic [FIELD_W-1:0] rs1,
    output logic [FIELD_W-1:0] rs2,
    output logic               halted,
    output logic [CNT_W-1:0]   issued_count
);

    fetch_state_e       r_state, w_state_next;
    logic [PC_W-1:0]    r_pc, w_pc_next;
    logic [INSTR_W-1:0] r_ir, w_ir_next;
    logic [CNT_W-1:0]   r_count, w_count_next;
    logic [FIELD_W-1:0] w_rdata_op;

    assign w_rdata_op = imem_rdata[OPC_LSB +: FIELD_W];

    // State, PC, instruction and counter registers; reset wins over any in-flight response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_pc    <= '0;
            r_ir    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
            r_count <= w_count_next;
        end
    end

    // Next-state logic: jump and halt are consumed here and never reach the issue stage
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        w_count_next = r_count;
        case (r_state)
            StIdle: begin
                if (start) w_state_next = StFetch;
            end
            StFetch: begin
                w_state_next = StWait;
            end
            StWait: begin
                if (imem_valid) begin
                    w_ir_next = imem_rdata;
                    if (w_rdata_op == OP_JUMP) begin
                        w_pc_next    = imem_rdata[PC_W-1:0];
                        w_state_next = StFetch;
                    end else if (w_rdata_op == OP_HALT) begin
                        w_state_next = StHalt;
                    end else begin
                        w_pc_next    = r_pc + 1'b1;
                        w_state_next = StIssue;
                    end
                end
            end
            StIssue: begin
                if (issue_ready) begin
                    if (r_count != '1) w_count_next = r_count + 1'b1;
                    w_state_next = StFetch;
                end
            end
            StHalt: begin
                w_state_next = StHalt;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Outputs come only from registers, so no input reaches an output combinationally
    assign imem_req     = (r_state == StFetch);
    assign imem_addr    = imem_req ? r_pc : '0;
    assign issue_valid  = (r_state == StIssue);
    assign halted       = (r_state == StHalt);
    assign opcode       = r_ir[OPC_LSB +: FIELD_W];
    assign rd           = r_ir[RD_LSB  +: FIELD_W];
    assign rs1          = r_ir[RS1_LSB +: FIELD_W];
    assign rs2          = r_ir[RS2_LSB +: FIELD_W];
    assign issued_count = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a delayed-response memory model and issue scoreboard.
module tb_instr_fetch_unit;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, issue_ready;
    logic        resp_valid = 1'b0;
    logic [15:0] resp_data  = 16'h0000;

    logic        imem_req, issue_valid, halted;
    logic [7:0]  imem_addr;
    logic [3:0]  opcode, rd, rs1, rs2;
    logic [15:0] issued_count;

    // Narrow-counter instance sharing the same inputs, for saturation
    logic        s_req, s_valid, s_halted;
    logic [7:0]  s_addr;
    logic [3:0]  s_op, s_rd, s_rs1, s_rs2;
    logic [1:0]  s_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [256];
    int          mem_delay = 0;
    logic        pend = 1'b0;
    logic [7:0]  pend_addr = 8'h00;
    int          pend_dly = 0;
    logic [15:0] sb_q [$];

    logic        prev_hold = 1'b0;
    logic [15:0] prev_fields = 16'h0000;
    logic [15:0] exp_word;

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(resp_valid), .imem_rdata(resp_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .halted(halted), .issued_count(issued_count)
    );

    instr_fetch_unit #(.PC_W(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(s_req), .imem_addr(s_addr),
        .imem_valid(resp_valid), .imem_rdata(resp_data),
        .issue_valid(s_valid), .issue_ready(issue_ready),
        .opcode(s_op), .rd(s_rd), .rs1(s_rs1), .rs2(s_rs2),
        .halted(s_halted), .issued_count(s_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_ivalid"}, 32'(issue_valid), 32'd0);
        chk({tag, "_fields"}, 32'({opcode, rd, rs1, rs2}), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_count"}, 32'(issued_count), 32'd0);
        chk({tag, "_scount"}, 32'(s_count), 32'd0);
    endtask

    task automatic check_fetch(input string tag, input logic [7:0] addr, input int cnt);
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, 32'(imem_addr), 32'(addr));
        chk({tag, "_ivalid"}, 32'(issue_valid), 32'd0);
        chk({tag, "_count"}, 32'(issued_count), 32'(cnt));
        chk({tag, "_scount"}, 32'(s_count), 32'(cnt > 3 ? 3 : cnt));
    endtask

    // Memory model: answers each request pend_dly cycles late; non-jump/halt words are expected
    always begin
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
        if (pend) begin
            if (pend_dly == 0) begin
                resp_valid = 1'b1;
                resp_data  = mem[pend_addr];
                pend       = 1'b0;
                if (resp_data[15:12] != OP_JUMP && resp_data[15:12] != OP_HALT)
                    sb_q.push_back(resp_data);
            end else begin
                pend_dly--;
            end
        end
        if (imem_req) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_dly  = mem_delay;
        end
    end

    // Issue monitor: pops the scoreboard on each accept and checks fields hold while stalled
    always @(negedge clk) begin
        if (prev_hold) begin
            chk("hold_valid", 32'(issue_valid), 32'd1);
            chk("hold_fields", 32'({opcode, rd, rs1, rs2}), 32'(prev_fields));
        end
        if (issue_valid && issue_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL issue_unexpected: observed=%0h expected=none", {opcode, rd, rs1, rs2});
            end else begin
                exp_word = sb_q.pop_front();
                chk("issue_fields", 32'({opcode, rd, rs1, rs2}), 32'(exp_word));
            end
        end
        prev_hold   = issue_valid && !issue_ready && !rst;
        prev_fields = {opcode, rd, rs1, rs2};
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0123;
        mem[8'h01] = 16'h4A5F;
        mem[8'h02] = 16'h1111;
        mem[8'h03] = 16'h6010;
        mem[8'h10] = 16'h2222;
        mem[8'h11] = 16'h60FF;
        mem[8'hFF] = 16'h3333;
        rst = 1'b1;
        start = 1'b0;
        issue_ready = 1'b1;

        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        chk("idle_req", 32'(imem_req), 32'd0);

        // start sampled at this edge -> request in the following cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        check_fetch("fetch0", 8'h00, 0);
        tick();
        chk("wait0_req", 32'(imem_req), 32'd0);
        chk("wait0_ivalid", 32'(issue_valid), 32'd0);
        tick();
        chk("issue0_valid", 32'(issue_valid), 32'd1);
        chk("issue0_fields", 32'({opcode, rd, rs1, rs2}), 32'h0123);
        tick();
        check_fetch("fetch1", 8'h01, 1);

        // Backpressure: hold ready low for 5 ISSUE cycles
        issue_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(issue_valid), 32'd1);
            chk("stall_fields", 32'({opcode, rd, rs1, rs2}), 32'h4A5F);
            chk("stall_req", 32'(imem_req), 32'd0);
            tick();
        end
        issue_ready = 1'b1;
        chk("stall_last_valid", 32'(issue_valid), 32'd1);
        tick();
        check_fetch("fetch2", 8'h02, 2);
        tick();
        tick();
        chk("issue2_fields", 32'({opcode, rd, rs1, rs2}), 32'h1111);
        tick();
        check_fetch("fetch3", 8'h03, 3);

        // Jump at addr 3: two cycles, never issued, not counted
        tick();
        chk("jwait_ivalid", 32'(issue_valid), 32'd0);
        tick();
        check_fetch("jump_target", 8'h10, 3);
        tick();
        tick();
        chk("issue10_fields", 32'({opcode, rd, rs1, rs2}), 32'h2222);
        tick();
        check_fetch("fetch11", 8'h11, 4);
        tick();
        mem_delay = 4;
        mem[8'h00] = 16'hF000;
        tick();
        check_fetch("jump_ff", 8'hFF, 4);

        // Slow memory: state holds WAIT, no further request pulses
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("slow_req", 32'(imem_req), 32'd0);
            chk("slow_ivalid", 32'(issue_valid), 32'd0);
        end
        tick();
        mem_delay = 0;
        chk("issueff_fields", 32'({opcode, rd, rs1, rs2}), 32'h3333);
        tick();
        check_fetch("pc_wrap", 8'h00, 5);

        // Halt
        tick();
        tick();
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_req", 32'(imem_req), 32'd0);
        chk("halt_ivalid", 32'(issue_valid), 32'd0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_start_halted", 32'(halted), 32'd1);
            chk("halt_start_req", 32'(imem_req), 32'd0);
        end
        start = 1'b0;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("halt_rst");

        // Reset landing in WAIT together with the memory response
        mem[8'h00] = 16'h5ABC;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_fetch("rw_fetch", 8'h00, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        check_reset_outputs("rst_in_wait");
        tick();
        tick();
        chk("post_rst_req", 32'(imem_req), 32'd0);
        chk("post_rst_ivalid", 32'(issue_valid), 32'd0);
        chk("post_rst_fields", 32'({opcode, rd, rs1, rs2}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
